// File: rtl/core_types_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : core_types_pkg
//  Description : Core-wide shared types and constants. Holds the PRF bank
//                geometry and the operand-source encoding used by the
//                operand collector.
//  Contents    : PRF_BANK_COUNT, LOG_PRF_BANK_COUNT, oc_src_t, clog2_min1()
//  Revision    : 1.0 - initial release
// ============================================================================
package core_types_pkg;

  localparam int PRF_BANK_COUNT     = 4;
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);

  // Where an operand comes from when its slot is enqueued.
  typedef enum logic [1:0] {
    OC_SRC_NONE = 2'd0,
    OC_SRC_REG  = 2'd1,
    OC_SRC_BUS  = 2'd2,
    OC_SRC_FAST = 2'd3
  } oc_src_t;

  // Index width that never collapses to zero bits for a count of 1.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_operand_collector_if.sv
`default_nettype none
// ============================================================================
//  Interface   : multi_operand_collector_if
//  Description : Issue-side, forwarding-side and consumer-side signals of the
//                multi-operand collector.
//  Modports    : master - issue queue / PRF / functional unit side (drives
//                         enqueue, responses, forwards, out_ready, flush)
//                slave  - the collector itself
//  Signals     : enq_*            slot enqueue request and per-operand source
//                reg_read_resp_*  per-lane register-read responses
//                bus_forward_*    PRF bus-forward data per bank
//                fast_forward_*   fast-forward valid/data per pipe
//                out_*            head-slot valid/ready/data
//                flush            kill all slots
//                reg_read_resp_error  response arrived with nothing to fill
//  Revision    : 1.0 - initial release
// ============================================================================
interface multi_operand_collector_if #(
  parameter int OPERAND_COUNT           = 2,
  parameter int FAST_FORWARD_PIPE_COUNT = 4,
  parameter int DATA_WIDTH              = 32
) ();

  localparam int LOG_FAST_FORWARD_PIPE_COUNT =
    core_types_pkg::clog2_min1(FAST_FORWARD_PIPE_COUNT);
  localparam int PRF_BANKS = core_types_pkg::PRF_BANK_COUNT;
  localparam int BANK_W    = core_types_pkg::LOG_PRF_BANK_COUNT;

  logic                                                    enq_valid;
  logic                                                    enq_ready;
  core_types_pkg::oc_src_t [OPERAND_COUNT-1:0]             enq_src;
  logic [OPERAND_COUNT-1:0][BANK_W-1:0]                    enq_bank;
  logic [OPERAND_COUNT-1:0][LOG_FAST_FORWARD_PIPE_COUNT-1:0] enq_fast_forward_pipe;

  logic [OPERAND_COUNT-1:0]                                reg_read_resp_valid_by_operand;
  logic [OPERAND_COUNT-1:0][DATA_WIDTH-1:0]                reg_read_resp_data_by_operand;
  logic [PRF_BANKS-1:0][DATA_WIDTH-1:0]                    bus_forward_data_by_bank;
  logic [FAST_FORWARD_PIPE_COUNT-1:0]                      fast_forward_data_valid_by_pipe;
  logic [FAST_FORWARD_PIPE_COUNT-1:0][DATA_WIDTH-1:0]      fast_forward_data_by_pipe;

  logic                                                    out_valid;
  logic                                                    out_ready;
  logic [OPERAND_COUNT-1:0][DATA_WIDTH-1:0]                out_data;

  logic                                                    flush;
  logic                                                    reg_read_resp_error;

  modport master (
    output enq_valid, enq_src, enq_bank, enq_fast_forward_pipe,
    output reg_read_resp_valid_by_operand, reg_read_resp_data_by_operand,
    output bus_forward_data_by_bank,
    output fast_forward_data_valid_by_pipe, fast_forward_data_by_pipe,
    output out_ready, flush,
    input  enq_ready, out_valid, out_data, reg_read_resp_error
  );

  modport slave (
    input  enq_valid, enq_src, enq_bank, enq_fast_forward_pipe,
    input  reg_read_resp_valid_by_operand, reg_read_resp_data_by_operand,
    input  bus_forward_data_by_bank,
    input  fast_forward_data_valid_by_pipe, fast_forward_data_by_pipe,
    input  out_ready, flush,
    output enq_ready, out_valid, out_data, reg_read_resp_error
  );

endinterface
`default_nettype wire

// File: rtl/multi_operand_collector_lane_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : oc_lane_tracker
//  Description : Per-operand-lane bookkeeping for register-read responses.
//                Keeps the in-order queue of slots waiting for a response on
//                this lane and the count of stale responses still owed after
//                a flush. Responses are consumed by stale drains first, then
//                by the oldest waiting slot.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                i_flush         discard all waiting slots (become drains)
//                i_push          a newly enqueued slot waits on this lane
//                i_push_slot     index of that slot
//                i_resp_valid    response strobe on this lane
//                o_fill          response fills o_fill_slot this cycle
//                o_fill_slot     slot index at the queue head
//                o_proto_err     response with nothing waiting or owed
//  Revision    : 1.0 - initial release
// ============================================================================
module oc_lane_tracker #(
  parameter int OC_ENTRIES = 4,
  parameter int IDX_W      = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_flush,
  input  wire logic             i_push,
  input  wire logic [IDX_W-1:0] i_push_slot,
  input  wire logic             i_resp_valid,
  output logic                  o_fill,
  output logic      [IDX_W-1:0] o_fill_slot,
  output logic                  o_proto_err
);

  localparam int CNT_W = $clog2(OC_ENTRIES + 1);
  // Several flushes may stack before their stale responses arrive.
  localparam int DRAIN_W = CNT_W + 4;

  logic [IDX_W-1:0]   r_q [OC_ENTRIES];
  logic [IDX_W-1:0]   r_rd;
  logic [IDX_W-1:0]   r_wr;
  logic [CNT_W-1:0]   r_cnt;
  logic [DRAIN_W-1:0] r_drain;

  logic w_has_pend;
  logic w_draining;
  logic w_drop;
  logic w_pop;

  function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(OC_ENTRIES - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  assign w_has_pend = (r_cnt != '0);
  assign w_draining = (r_drain != '0);
  assign w_drop     = i_resp_valid & w_draining;
  assign w_pop      = i_resp_valid & ~w_draining & w_has_pend;

  // A fill during a flush would land in a slot that is being killed.
  assign o_fill      = w_pop & ~i_flush;
  assign o_fill_slot = r_q[r_rd];
  assign o_proto_err = i_resp_valid & ~w_draining & ~w_has_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_cnt   <= '0;
      r_drain <= '0;
    end else if (i_flush) begin
      // Every waiting slot still gets its response; count them as stale.
      // A response arriving in this same cycle retires one of them.
      r_rd    <= '0;
      r_wr    <= '0;
      r_cnt   <= '0;
      r_drain <= r_drain + DRAIN_W'(r_cnt) - DRAIN_W'(w_drop | w_pop);
    end else begin
      if (i_push) begin
        r_q[r_wr] <= i_push_slot;
        r_wr      <= f_next(r_wr);
      end
      if (w_pop) begin
        r_rd <= f_next(r_rd);
      end
      r_cnt   <= r_cnt + CNT_W'(i_push) - CNT_W'(w_pop);
      r_drain <= r_drain - DRAIN_W'(w_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!o_proto_err)
        else $warning("oc_lane_tracker: reg-read response with nothing pending was ignored");
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_operand_collector.sv
`default_nettype none
// ============================================================================
//  Module      : multi_operand_collector
//  Description : FIFO of OC_ENTRIES issue slots, each collecting
//                OPERAND_COUNT operands from register-read responses, PRF
//                bus forwards or fast-forward pipes. The oldest slot is
//                released over valid/ready once all its operands are in.
//                Flush kills all slots and drains stale responses.
//  Ports       : CLK, RST  clock, synchronous active-high reset
//                oc_if     multi_operand_collector_if.slave (enqueue,
//                          responses, forwards, output handshake, flush)
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_operand_collector
  import core_types_pkg::*;
#(
  parameter int OC_ENTRIES              = 4,
  parameter int OPERAND_COUNT           = 2,
  parameter int FAST_FORWARD_PIPE_COUNT = 4,
  parameter int DATA_WIDTH              = 32
) (
  input  wire logic                    CLK,
  input  wire logic                    RST,
  multi_operand_collector_if.slave     oc_if
);

  localparam int LOG_OC_ENTRIES = clog2_min1(OC_ENTRIES);
  localparam int CNT_W          = $clog2(OC_ENTRIES + 1);

  typedef logic [LOG_OC_ENTRIES-1:0] slot_idx_t;
  typedef logic [OPERAND_COUNT-1:0][DATA_WIDTH-1:0] slot_data_t;

  // Slot storage
  logic       [OC_ENTRIES-1:0]                    r_slot_valid;
  logic       [OC_ENTRIES-1:0][OPERAND_COUNT-1:0] r_collected;
  slot_data_t [OC_ENTRIES-1:0]                    r_data;
  slot_idx_t                                      r_head;
  slot_idx_t                                      r_tail;
  logic       [CNT_W-1:0]                         r_count;

  // BUS capture scheduled for the cycle after enqueue
  logic                                            r_bus_pend;
  slot_idx_t                                       r_bus_slot;
  logic [OPERAND_COUNT-1:0]                        r_bus_mask;
  logic [OPERAND_COUNT-1:0][LOG_PRF_BANK_COUNT-1:0] r_bus_bank;

  // Enqueue decode
  logic [OPERAND_COUNT-1:0] w_enq_collect;
  logic [OPERAND_COUNT-1:0] w_enq_reg;
  logic [OPERAND_COUNT-1:0] w_enq_bus;
  slot_data_t               w_enq_data;

  logic w_enq_ready;
  logic w_enq_fire;
  logic w_out_valid;
  logic w_deq_fire;

  // Lane tracker results
  logic      w_fill      [OPERAND_COUNT];
  slot_idx_t w_fill_slot [OPERAND_COUNT];
  logic      w_lane_err  [OPERAND_COUNT];
  logic      w_any_err;

  function automatic slot_idx_t f_next(input slot_idx_t p);
    return (p == slot_idx_t'(OC_ENTRIES - 1)) ? '0 : p + slot_idx_t'(1);
  endfunction

  // Occupancy alone decides readiness, so a full FIFO never accepts even
  // when the head is leaving in the same cycle.
  assign w_enq_ready = (r_count != CNT_W'(OC_ENTRIES));
  assign w_enq_fire  = oc_if.enq_valid & w_enq_ready & ~oc_if.flush;
  assign w_out_valid = r_slot_valid[r_head] & (&r_collected[r_head]);
  assign w_deq_fire  = w_out_valid & oc_if.out_ready & ~oc_if.flush;

  assign oc_if.enq_ready           = w_enq_ready;
  assign oc_if.out_valid           = w_out_valid;
  assign oc_if.out_data            = r_data[r_head];
  assign oc_if.reg_read_resp_error = w_any_err;

  // A FAST operand whose pipe is not valid this cycle waits on its
  // register-read lane instead.
  always_comb begin
    w_enq_collect = '0;
    w_enq_reg     = '0;
    w_enq_bus     = '0;
    w_enq_data    = '0;
    for (int i = 0; i < OPERAND_COUNT; i++) begin
      case (oc_if.enq_src[i])
        OC_SRC_NONE: w_enq_collect[i] = 1'b1;
        OC_SRC_FAST: begin
          if (oc_if.fast_forward_data_valid_by_pipe[oc_if.enq_fast_forward_pipe[i]]) begin
            w_enq_collect[i] = 1'b1;
            w_enq_data[i]    = oc_if.fast_forward_data_by_pipe[oc_if.enq_fast_forward_pipe[i]];
          end else begin
            w_enq_reg[i] = 1'b1;
          end
        end
        OC_SRC_BUS:  w_enq_bus[i] = 1'b1;
        OC_SRC_REG:  w_enq_reg[i] = 1'b1;
        default:     w_enq_collect[i] = 1'b1;
      endcase
    end
  end

  generate
    for (genvar g = 0; g < OPERAND_COUNT; g++) begin : g_lane
      oc_lane_tracker #(
        .OC_ENTRIES (OC_ENTRIES),
        .IDX_W      (LOG_OC_ENTRIES)
      ) u_tracker (
        .clk          (CLK),
        .rst          (RST),
        .i_flush      (oc_if.flush),
        .i_push       (w_enq_fire & w_enq_reg[g]),
        .i_push_slot  (r_tail),
        .i_resp_valid (oc_if.reg_read_resp_valid_by_operand[g]),
        .o_fill       (w_fill[g]),
        .o_fill_slot  (w_fill_slot[g]),
        .o_proto_err  (w_lane_err[g])
      );
    end
  endgenerate

  always_comb begin
    w_any_err = 1'b0;
    for (int i = 0; i < OPERAND_COUNT; i++) begin
      w_any_err = w_any_err | w_lane_err[i];
    end
  end

  // Fills, BUS captures and the enqueue all target different (slot, operand)
  // cells: fills and captures only hit occupied slots, the enqueue hits the
  // free tail slot.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_slot_valid <= '0;
      r_collected  <= '0;
      r_data       <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_bus_pend   <= 1'b0;
      r_bus_slot   <= '0;
      r_bus_mask   <= '0;
      r_bus_bank   <= '0;
    end else if (oc_if.flush) begin
      r_slot_valid <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_bus_pend   <= 1'b0;
    end else begin
      if (r_bus_pend) begin
        for (int i = 0; i < OPERAND_COUNT; i++) begin
          if (r_bus_mask[i]) begin
            r_data[r_bus_slot][i]      <= oc_if.bus_forward_data_by_bank[r_bus_bank[i]];
            r_collected[r_bus_slot][i] <= 1'b1;
          end
        end
      end

      for (int i = 0; i < OPERAND_COUNT; i++) begin
        if (w_fill[i]) begin
          r_data[w_fill_slot[i]][i]      <= oc_if.reg_read_resp_data_by_operand[i];
          r_collected[w_fill_slot[i]][i] <= 1'b1;
        end
      end

      r_bus_pend <= w_enq_fire & (|w_enq_bus);
      if (w_enq_fire) begin
        r_slot_valid[r_tail] <= 1'b1;
        r_collected[r_tail]  <= w_enq_collect;
        r_data[r_tail]       <= w_enq_data;
        r_bus_slot           <= r_tail;
        r_bus_mask           <= w_enq_bus;
        r_bus_bank           <= oc_if.enq_bank;
        r_tail               <= f_next(r_tail);
      end

      if (w_deq_fire) begin
        r_slot_valid[r_head] <= 1'b0;
        r_head               <= f_next(r_head);
      end

      r_count <= r_count + CNT_W'(w_enq_fire) - CNT_W'(w_deq_fire);
    end
  end

endmodule
`default_nettype wire

// File: doc/multi_operand_collector.md
# multi_operand_collector

Parametrised successor to the single-operand collector: a FIFO of OC_ENTRIES issue slots, each gathering OPERAND_COUNT operands independently from PRF register-read responses, PRF bus forwards, or fast-forward pipes. The block sits between an issue queue and its functional unit. It releases the oldest slot over a valid/ready handshake once every operand of that slot is collected. A flush discards all slots and silently drains stale register-read responses.

## Interface
Parameters:
- OC_ENTRIES, 4, slot count; any value ≥2, not required to be a power of 2.
- OPERAND_COUNT, 2, operands per slot.
- FAST_FORWARD_PIPE_COUNT, 4, number of fast-forward sources.
- DATA_WIDTH, 32, operand width.
- Derived: LOG_OC_ENTRIES, LOG_FAST_FORWARD_PIPE_COUNT (both $clog2). PRF_BANK_COUNT and LOG_PRF_BANK_COUNT come from core_types_pkg.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous and active-high. One clock; reset is synchronous and active-high.
- enq_valid  in  1  slot enqueue request.
- enq_ready  out  1  high when the FIFO is not full.
- enq_src  in  [OPERAND_COUNT] oc_src_t  source of each operand: NONE, REG, BUS or FAST.
- enq_bank  in  [OPERAND_COUNT][LOG_PRF_BANK_COUNT]  PRF bank for a BUS operand.
- enq_fast_forward_pipe  in  [OPERAND_COUNT][LOG_FAST_FORWARD_PIPE_COUNT]  pipe for a FAST operand.
- reg_read_resp_valid_by_operand  in  [OPERAND_COUNT]  register-read response strobe, one per operand lane.
- reg_read_resp_data_by_operand  in  [OPERAND_COUNT][DATA_WIDTH]  register-read response data.
- bus_forward_data_by_bank  in  [PRF_BANK_COUNT][DATA_WIDTH]  PRF bus-forward data.
- fast_forward_data_valid_by_pipe  in  [FAST_FORWARD_PIPE_COUNT]  fast-forward valid per pipe.
- fast_forward_data_by_pipe  in  [FAST_FORWARD_PIPE_COUNT][DATA_WIDTH]  fast-forward data per pipe.
- out_valid  out  1  head slot is fully collected.
- out_ready  in  1  consumer accepts the head slot.
- out_data  out  [OPERAND_COUNT][DATA_WIDTH]  operands of the head slot.
- flush  in  1  kill all slots.

## Operation
- An enqueue fires when enq_valid & enq_ready. The slot is written at the tail pointer and the tail advances modulo OC_ENTRIES.
- Per-operand capture:
  - NONE: data is 0 and the operand is collected at enqueue.
  - FAST: if fast_forward_data_valid_by_pipe[pipe] is high in the enqueue cycle, the data is captured and the operand is collected. If it is low, the operand falls back to REG.
  - BUS: captured from bus_forward_data_by_bank[bank] exactly 1 cycle after enqueue.
  - REG: waits for a response on its own operand lane. Responses on lane i arrive in enqueue order across the slots whose operand i is REG.
- Each lane has a reg-pending queue of slot indices, at most OC_ENTRIES deep. A response always fills the oldest pending slot on that lane.
- out_valid is high when the head slot is valid and all its operands are collected. A dequeue fires on out_valid & out_ready, and the head advances.
- Flush:
  - Invalidates every slot.
  - Sets drain_cnt[i] += (number of pending REG operands on lane i).
  - While drain_cnt[i] > 0, each response on lane i is dropped and decrements drain_cnt[i]. Drained responses never fill new slots.
  - A BUS capture pending in the flush cycle is discarded.
- A response arriving when no REG operand is pending and drain_cnt is 0 is a protocol error. It is ignored and flagged by an assertion.

## Timing
- Reset values: out_valid 0, out_data all 0, enq_ready 1. All pointers, counters, drain_cnt and slot-valid bits are 0.
- Latency from enqueue in cycle N:
  - NONE or FAST operands only: out_valid in N+1.
  - Any BUS operand: out_valid in N+2.
  - REG operand: a response in cycle M gives out_valid in M+1, if it is the last operand outstanding.
- No same-cycle bypass from enqueue to output.
- enq_ready depends only on the registered occupancy. There is no enqueue pass-through when the FIFO is full, even with a simultaneous dequeue.
- Enqueue and dequeue in the same cycle leave the count unchanged.
- A response in the enqueue cycle of slot S can only fill an older slot.
- Flush has priority: enqueue and dequeue are ignored in the flush cycle, and enq_ready is 1 on the next cycle.
- RST asserted mid-collection clears everything, including drain_cnt, on the next edge.

## Structure
- core_types_pkg gets the typedef oc_src_t, a 2-bit enum {OC_SRC_NONE, OC_SRC_REG, OC_SRC_BUS, OC_SRC_FAST}.
- PRF_BANK_COUNT and LOG_PRF_BANK_COUNT stay in core_types_pkg.
- One sub-module, oc_lane_tracker, is instantiated once per operand lane. It holds the lane's reg-pending slot FIFO and drain_cnt and produces the fill strobe and slot index.

## Test plan
- Enqueue {FAST pipe 2 valid, data 0xA5A5_0001; NONE} in cycle 5 -> out_valid in cycle 6 with out_data {0xA5A5_0001, 0}; dequeue drops out_valid.
- Enqueue {BUS bank 1, REG}; drive bus bank 1 = 0x1234 in cycle N+1 and the REG response 0xBEEF in N+3 -> out_valid in N+4 with {0x1234, 0xBEEF}.
- OC_ENTRIES=3: three REG-only enqueues give enq_ready 0. Responses 1, 2, 3 in order fill slots in enqueue order. Six total enqueue/dequeue cycles check pointer wrap.
- FAST with pipe valid low, then a REG response 0x77 -> operand taken as 0x77.
- Two slots pending REG on lane 0, flush, then enqueue a new REG slot. Responses 0x1, 0x2, 0x3 -> the first two are dropped, and the new slot outputs 0x3.
- RST pulse while 2 slots are pending -> next cycle out_valid 0, enq_ready 1, and a later response is flagged as a protocol error.
